// File: rtl/perf_event_monitor.sv
// rtl/perf_event_monitor.sv - run-window cycle and pipeline event counters
module perf_event_monitor #(
    parameter int NUM_EVENTS  = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int CYCLE_LIMIT = 18,
    parameter int SATURATE    = 0,
    localparam int SEL_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  freeze_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic [CNT_WIDTH-1:0]  cycle_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic [NUM_EVENTS-1:0] overflow_o
);

    // Bad parameterisations stop elaboration instead of silently truncating.
    if (NUM_EVENTS < 1 || NUM_EVENTS > 16) begin : g_bad_num_events
        $error("perf_event_monitor: NUM_EVENTS must be 1..16");
    end
    if (CYCLE_LIMIT < 0 || (64'(CYCLE_LIMIT) >> CNT_WIDTH) != 64'd0) begin : g_bad_cycle_limit
        $error("perf_event_monitor: CYCLE_LIMIT does not fit in CNT_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] LIMIT   = CNT_WIDTH'(CYCLE_LIMIT);

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   cycle_q;
    logic [CNT_WIDTH-1:0]   cycle_inc;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]  ovf_q;

    // Post-increment cycle count; always saturating so a limitless run never wraps.
    always_comb begin
        cycle_inc = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + 1'b1;
    end

    // Next state: limit check beats a pause on the same edge; DONE is only left via reset/clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (CYCLE_LIMIT != 0 && cycle_inc == LIMIT) begin
                    state_d = ST_DONE;
                end else if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; clear acts like reset on the whole block.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cycle counter advances on every edge spent in RUN, including the leaving edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cycle_q <= '0;
        end else if (state_q == ST_RUN) begin
            cycle_q <= cycle_inc;
        end
    end

    // Event counters with sticky overflow; freeze gates events but not cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (state_q == ST_RUN && !freeze_i) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (event_i[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_q[i] <= 1'b1;
                        if (SATURATE == 0) begin
                            cnt_q[i] <= '0;
                        end
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Read mux; out-of-range selects read as zero.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (sel_i == SEL_W'(i)) begin
                cnt_o = cnt_q[i];
            end
        end
    end

    assign cycle_o    = cycle_q;
    assign running_o  = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign overflow_o = ovf_q;

endmodule
